// File: rtl/sm_pkg.sv
// Shared types and helpers for the sign-magnitude min/max tracker.
// Holds the FSM state enum, the -0 constant and the sign normaliser.
package sm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  localparam int SM_W_MAX = 64;

  // Encoding of negative zero (sign set, magnitude clear) for width n.
  function automatic logic [SM_W_MAX-1:0] SM_NEG_ZERO(input int n);
    return {{(SM_W_MAX-1){1'b0}}, 1'b1} << (n - 1);
  endfunction

  // Effective sign: a zero magnitude is always treated as positive.
  function automatic logic sm_norm(
    input logic sign,
    input logic mag_zero
  );
    return sign & ~mag_zero;
  endfunction

endpackage

// File: rtl/sm_minmax_tracker_cmp.sv
// Combinational sign-magnitude comparator: o_out = (in_a >= in_b).
// Ports: in_a, in_b (N-bit sign-magnitude), o_out (1 bit). +0 == -0.
module sm_minmax_tracker_cmp
  import sm_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         o_out
);

  logic         a_neg;
  logic         b_neg;
  logic [N-2:0] a_mag;
  logic [N-2:0] b_mag;

  assign a_mag = in_a[N-2:0];
  assign b_mag = in_b[N-2:0];
  assign a_neg = sm_norm(in_a[N-1], ~|a_mag);
  assign b_neg = sm_norm(in_b[N-1], ~|b_mag);

  always_comb begin
    o_out = 1'b0;
    if (a_neg != b_neg) begin
      o_out = ~a_neg;
    end else if (!a_neg) begin
      o_out = (a_mag >= b_mag);
    end else begin
      o_out = (a_mag <= b_mag);
    end
  end

endmodule

// File: rtl/sm_minmax_tracker.sv
// Frame-based running max/min of sign-magnitude samples (valid/ready in).
// Ports: i_clk, i_rst_n (async low), i_start, i_valid/o_ready, i_data,
// o_res_valid/i_res_ready, o_max, o_min; o_max_idx/o_min_idx only
// when SM_MINMAX_IDX_EN is defined.
module sm_minmax_tracker
  import sm_pkg::*;
#(
  parameter int N         = 8,
  parameter int FRAME_LEN = 16,
  localparam int CW = $clog2(FRAME_LEN + 1),
  localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [N-1:0]  i_data,
  output logic          o_res_valid,
  input  logic          i_res_ready,
  output logic [N-1:0]  o_max,
  output logic [N-1:0]  o_min
`ifdef SM_MINMAX_IDX_EN
  ,
  output logic [IW-1:0] o_max_idx,
  output logic [IW-1:0] o_min_idx
`endif
);

  localparam logic [N-1:0]  NZ   = N'(SM_NEG_ZERO(N));
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  max_q, max_d;
  logic [N-1:0]  min_q, min_d;
  logic [N-1:0]  samp;
  logic          accept;
  logic          first;
  logic          max_keep;
  logic          min_keep;

  assign samp   = (i_data == NZ) ? '0 : i_data;
  assign accept = (state_q == ACCUM) && i_valid;
  assign first  = (count_q == '0);

  sm_minmax_tracker_cmp #(.N(N)) u_max_cmp (
    .in_a  (max_q),
    .in_b  (samp),
    .o_out (max_keep)
  );

  sm_minmax_tracker_cmp #(.N(N)) u_min_cmp (
    .in_a  (samp),
    .in_b  (min_q),
    .o_out (min_keep)
  );

`ifdef SM_MINMAX_IDX_EN
  logic [IW-1:0] max_idx_q, max_idx_d;
  logic [IW-1:0] min_idx_q, min_idx_d;

  always_comb begin
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
    if (accept) begin
      if (first) begin
        max_idx_d = '0;
        min_idx_d = '0;
      end else begin
        if (!max_keep) max_idx_d = IW'(count_q);
        if (!min_keep) min_idx_d = IW'(count_q);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      max_idx_q <= '0;
      min_idx_q <= '0;
    end else begin
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
    end
  end

  assign o_max_idx = max_idx_q;
  assign o_min_idx = min_idx_q;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    max_d   = max_q;
    min_d   = min_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = ACCUM;
          count_d = '0;
        end
      end
      ACCUM: begin
        if (accept) begin
          count_d = count_q + CW'(1);
          if (first) begin
            max_d = samp;
            min_d = samp;
          end else begin
            if (!max_keep) max_d = samp;
            if (!min_keep) min_d = samp;
          end
          if (count_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        if (i_res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      max_q   <= '0;
      min_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      max_q   <= max_d;
      min_q   <= min_d;
    end
  end

  assign o_ready     = (state_q == ACCUM);
  assign o_res_valid = (state_q == DONE);
  assign o_max       = max_q;
  assign o_min       = min_q;

endmodule

// File: tb/tb_sm_minmax_tracker.sv
// Bench for sm_minmax_tracker: behavioural model + per-cycle compare,
// directed frames, random frames, async reset and a FRAME_LEN=1 DUT.
module tb_sm_minmax_tracker;

  localparam int N  = 8;
  localparam int FL = 5;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic       res_ready = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       o_ready;
  logic       o_res_valid;
  logic [7:0] o_max;
  logic [7:0] o_min;

  logic       start1 = 1'b0;
  logic       valid1 = 1'b0;
  logic       res_ready1 = 1'b0;
  logic [7:0] data1  = 8'h00;
  logic       o_ready1;
  logic       o_res_valid1;
  logic [7:0] o_max1;
  logic [7:0] o_min1;

`ifdef SM_MINMAX_IDX_EN
  logic [2:0] o_max_idx;
  logic [2:0] o_min_idx;
  logic [0:0] o_max_idx1;
  logic [0:0] o_min_idx1;
`endif

  always #5 clk = ~clk;

  sm_minmax_tracker #(.N(N), .FRAME_LEN(FL)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_valid     (valid),
    .o_ready     (o_ready),
    .i_data      (data),
    .o_res_valid (o_res_valid),
    .i_res_ready (res_ready),
    .o_max       (o_max),
    .o_min       (o_min)
`ifdef SM_MINMAX_IDX_EN
    ,
    .o_max_idx   (o_max_idx),
    .o_min_idx   (o_min_idx)
`endif
  );

  sm_minmax_tracker #(.N(N), .FRAME_LEN(1)) dut1 (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start1),
    .i_valid     (valid1),
    .o_ready     (o_ready1),
    .i_data      (data1),
    .o_res_valid (o_res_valid1),
    .i_res_ready (res_ready1),
    .o_max       (o_max1),
    .o_min       (o_min1)
`ifdef SM_MINMAX_IDX_EN
    ,
    .o_max_idx   (o_max_idx1),
    .o_min_idx   (o_min_idx1)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: signed value of a sign-magnitude byte.
  function automatic int sval(input logic [7:0] x);
    return x[7] ? -int'(x[6:0]) : int'(x[6:0]);
  endfunction

  function automatic logic [7:0] nrm(input logic [7:0] x);
    return (x == 8'h80) ? 8'h00 : x;
  endfunction

  int         m_st = 0;
  logic [7:0] m_q[$];
  logic [7:0] m_max = 8'h00;
  logic [7:0] m_min = 8'h00;
  int         m_maxi = 0;
  int         m_mini = 0;

  // Model: 0 = waiting for start, 1 = collecting, 2 = result held.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_st = 0;
      m_q.delete();
      m_max = 8'h00;
      m_min = 8'h00;
      m_maxi = 0;
      m_mini = 0;
    end else begin
      case (m_st)
        0: if (start) begin
          m_st = 1;
          m_q.delete();
        end
        1: if (valid) begin
          m_q.push_back(nrm(data));
          m_maxi = 0;
          m_mini = 0;
          for (int i = 1; i < m_q.size(); i++) begin
            if (sval(m_q[i]) > sval(m_q[m_maxi])) m_maxi = i;
            if (sval(m_q[i]) < sval(m_q[m_mini])) m_mini = i;
          end
          m_max = m_q[m_maxi];
          m_min = m_q[m_mini];
          if (m_q.size() == FL) m_st = 2;
        end
        default: if (res_ready) m_st = 0;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    chk("ready", 32'(o_ready), 32'(m_st == 1));
    chk("res_valid", 32'(o_res_valid), 32'(m_st == 2));
    chk("max", 32'(o_max), 32'(m_max));
    chk("min", 32'(o_min), 32'(m_min));
`ifdef SM_MINMAX_IDX_EN
    chk("max_idx", 32'(o_max_idx), 32'(m_maxi));
    chk("min_idx", 32'(o_min_idx), 32'(m_mini));
`endif
  end

  logic [7:0] c1[FL] = '{8'h05, 8'h83, 8'h7F, 8'hFF, 8'h00};
  logic [7:0] c2[FL] = '{8'h03, 8'h03, 8'h81, 8'h81, 8'h03};
  logic [7:0] c3[FL] = '{8'h80, 8'h00, 8'h80, 8'h00, 8'h80};
  logic [7:0] c5[FL] = '{8'h11, 8'h92, 8'h33, 8'h44, 8'h55};
  logic [7:0] cr[FL];

  // Drives one frame; stops after abort_at accepts or with result held.
  task automatic run_frame(input logic [7:0] s[FL],
                           input int gap_pct,
                           input int abort_at);
    int idx = 0;
    int cyc = 0;
    bit pend = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (1) begin
      if (pend) idx++;
      pend = 1'b0;
      if (idx == FL || idx == abort_at || cyc > 200) break;
      valid = ($urandom_range(99) >= gap_pct);
      data  = valid ? s[idx] : 8'($urandom);
      pend  = valid && o_ready;
      cyc++;
      @(negedge clk);
    end
    valid = 1'b0;
    chk("accept_budget", 32'(cyc <= 200), 32'd1);
    if (idx != abort_at) begin
      cyc = 0;
      while (!o_res_valid && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      chk("done_wait", 32'(o_res_valid), 32'd1);
    end
  endtask

  task automatic release_res(input int hold);
    repeat (hold) @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic lit(input string name,
                     input logic [7:0] mx,
                     input logic [7:0] mn,
                     input int mxi,
                     input int mni);
    chk({name, "_max"}, 32'(o_max), 32'(mx));
    chk({name, "_min"}, 32'(o_min), 32'(mn));
    chk({name, "_model_max"}, 32'(m_max), 32'(mx));
    chk({name, "_model_min"}, 32'(m_min), 32'(mn));
    chk({name, "_model_idx"}, 32'(m_maxi * 8 + m_mini),
        32'(mxi * 8 + mni));
`ifdef SM_MINMAX_IDX_EN
    chk({name, "_max_idx"}, 32'(o_max_idx), 32'(mxi));
    chk({name, "_min_idx"}, 32'(o_min_idx), 32'(mni));
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_res_valid", 32'(o_res_valid), 32'd0);
    chk("rst_max", 32'(o_max), 32'd0);
    chk("rst_min", 32'(o_min), 32'd0);
    chk("rst_res_valid1", 32'(o_res_valid1), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", 32'(o_ready), 32'd0);

    run_frame(c1, 0, -1);
    lit("case1", 8'h7F, 8'hFF, 2, 3);
    release_res(0);
    chk("idle_after", 32'(o_ready), 32'd0);
    chk("idle_hold_max", 32'(o_max), 32'h7F);

    run_frame(c2, 0, -1);
    lit("case2", 8'h03, 8'h81, 0, 2);
    release_res(1);

    run_frame(c3, 0, -1);
    lit("case3", 8'h00, 8'h00, 0, 0);
    release_res(0);

    run_frame(c1, 50, -1);
    lit("case4", 8'h7F, 8'hFF, 2, 3);
    repeat (5) @(negedge clk);
    lit("case4_held", 8'h7F, 8'hFF, 2, 3);
    chk("case4_ready", 32'(o_ready), 32'd0);
    release_res(0);

    run_frame(c5, 0, 3);
    chk("case5_pre_max", 32'(o_max), 32'h33);
    #2 rst_n = 1'b0;
    #1;
    chk("case5_ready", 32'(o_ready), 32'd0);
    chk("case5_res_valid", 32'(o_res_valid), 32'd0);
    chk("case5_max", 32'(o_max), 32'd0);
    chk("case5_min", 32'(o_min), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(c5, 30, -1);
    lit("case5_next", 8'h55, 8'h92, 4, 1);
    release_res(2);

    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < FL; i++) cr[i] = 8'($urandom);
      if (f == 0) cr[3] = 8'h80;
      run_frame(cr, $urandom_range(60), -1);
      release_res($urandom_range(3));
    end

    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    chk("fl1_ready", 32'(o_ready1), 32'd1);
    @(negedge clk);
    chk("fl1_stray_ready", 32'(o_ready1), 32'd1);
    chk("fl1_stray_rv", 32'(o_res_valid1), 32'd0);
    valid1 = 1'b1;
    data1  = 8'h9A;
    @(negedge clk);
    valid1 = 1'b0;
    repeat (3) begin
      chk("fl1_res_valid", 32'(o_res_valid1), 32'd1);
      chk("fl1_ready_done", 32'(o_ready1), 32'd0);
      chk("fl1_max", 32'(o_max1), 32'h9A);
      chk("fl1_min", 32'(o_min1), 32'h9A);
`ifdef SM_MINMAX_IDX_EN
      chk("fl1_idx", 32'({o_max_idx1, o_min_idx1}), 32'd0);
`endif
      @(negedge clk);
    end
    start1 = 1'b0;
    res_ready1 = 1'b1;
    @(negedge clk);
    res_ready1 = 1'b0;
    chk("fl1_idle_rv", 32'(o_res_valid1), 32'd0);
    chk("fl1_idle_ready", 32'(o_ready1), 32'd0);
    chk("fl1_idle_max", 32'(o_max1), 32'h9A);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
